// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 asynchronous serial receiver with a two-flop input
// synchroniser and a one-entry ready/valid output register.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LIM_H = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] LIM_N = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_frame_err;
  logic            r_overrun;
  logic            r_sync1;
  logic            r_sync2;

  logic            w_rxd_s;
  logic            w_done;
  logic            w_accept;

  // Both flops reset high so a released reset looks like an idle line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxd_s  = r_sync2;
  assign w_done   = (r_state == S_STOP) && (r_cnt == LIM_N) && w_rxd_s;
  assign w_accept = r_valid && ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rxd_s) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == LIM_H) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rxd_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == LIM_N) begin
            r_cnt   <= '0;
            r_shift <= {w_rxd_s, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == LIM_N) begin
            r_cnt <= '0;
            if (w_rxd_s) begin
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // A held-low line (break) must not be re-read as a stream of zero bytes.
        S_WAIT_HIGH: begin
          r_cnt <= '0;
          if (w_rxd_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // A completing byte always wins the register; overrun only when it displaces an unaccepted byte.
      if (w_done) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        if (r_valid && !ready) r_overrun <= 1'b1;
      end else if (w_accept) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
